// File: rtl/bus_bridge_mc_pkg.sv
// Shared types and default address map for the CPU data-bus bridge.
package bus_bridge_mc_pkg;

  typedef enum logic [1:0] {
    BB_IDLE = 2'd0,
    BB_WAIT = 2'd1,
    BB_DONE = 2'd2
  } bb_state_e;

  localparam int BB_CNT_W = 8;

  // Default 4-channel map: DRAM, I/O page, two peripheral windows.
  localparam logic [4*32-1:0] BB_DEF_BASE = {
    32'h2100_0000, 32'h2000_0000, 32'hFFFF_F000, 32'h0000_0000
  };
  localparam logic [4*32-1:0] BB_DEF_MASK = {
    32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_F000, 32'hF000_0000
  };

  function automatic logic [BB_CNT_W-1:0] bb_last_wait(input int tmo);
    return BB_CNT_W'(tmo - 1);
  endfunction

endpackage

// File: rtl/bus_bridge_mc_addr_dec.sv
// Address decoder: per-channel window match, lowest matching index selected.
module bb_addr_dec #(
  parameter int              NCH  = 4,
  parameter int              AW   = 32,
  parameter logic [NCH*AW-1:0] BASE = '0,
  parameter logic [NCH*AW-1:0] MASK = '0
) (
  input  logic [AW-1:0]  cpu_addr,
  output logic [NCH-1:0] sel,
  output logic           hit
);

  logic [NCH-1:0] w_match;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_match[i] = (cpu_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW];
  end

  // x & -x isolates the lowest set bit: priority without a loop chain.
  assign sel = w_match & (~w_match + NCH'(1));
  assign hit = |w_match;

endmodule

// File: rtl/bus_bridge_mc.sv
// Multi-cycle CPU-to-peripheral bridge: decode, hold request until ack or
// timeout, return a registered one-cycle ready/err response.
module bus_bridge_mc
  import bus_bridge_mc_pkg::*;
#(
  parameter int                NCH     = 4,
  parameter int                AW      = 32,
  parameter int                DW      = 32,
  parameter int                TIMEOUT = 15,
  parameter logic [NCH*AW-1:0] BASE    = (NCH*AW)'(BB_DEF_BASE),
  parameter logic [NCH*AW-1:0] MASK    = (NCH*AW)'(BB_DEF_MASK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic [NCH-1:0]    ch_req,
  output logic              ch_we,
  output logic [AW-1:0]     ch_addr,
  output logic [DW-1:0]     ch_wdata,
  input  logic [NCH*DW-1:0] ch_rdata,
  input  logic [NCH-1:0]    ch_ack
);

  localparam logic [BB_CNT_W-1:0] LP_LAST = bb_last_wait(TIMEOUT);

  bb_state_e             r_state, w_state_nx;
  logic [BB_CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [NCH-1:0]        r_ch_req, w_ch_req_nx;
  logic                  r_ch_we, w_ch_we_nx;
  logic [AW-1:0]         r_ch_addr, w_ch_addr_nx;
  logic [DW-1:0]         r_ch_wdata, w_ch_wdata_nx;
  logic [DW-1:0]         r_rdata, w_rdata_nx;
  logic                  r_ready, w_ready_nx;
  logic                  r_err, w_err_nx;

  logic [NCH-1:0]        w_sel;
  logic                  w_hit;
  logic                  w_ack;
  logic [DW-1:0]         w_sel_rdata;

  bb_addr_dec #(
    .NCH  (NCH),
    .AW   (AW),
    .BASE (BASE),
    .MASK (MASK)
  ) u_dec (
    .cpu_addr (cpu_addr),
    .sel      (w_sel),
    .hit      (w_hit)
  );

  // Only the selected channel's ack counts; others are masked off.
  assign w_ack = |(ch_ack & r_ch_req);

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NCH; i++)
      if (r_ch_req[i]) w_sel_rdata = w_sel_rdata | ch_rdata[i*DW +: DW];
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_ch_req_nx   = r_ch_req;
    w_ch_we_nx    = r_ch_we;
    w_ch_addr_nx  = r_ch_addr;
    w_ch_wdata_nx = r_ch_wdata;
    w_rdata_nx    = r_rdata;
    w_ready_nx    = 1'b0;
    w_err_nx      = 1'b0;
    case (r_state)
      BB_IDLE: begin
        if (cpu_req) begin
          if (w_hit) begin
            w_ch_we_nx    = cpu_we;
            w_ch_addr_nx  = cpu_addr;
            w_ch_wdata_nx = cpu_wdata;
            w_ch_req_nx   = w_sel;
            w_cnt_nx      = '0;
            w_state_nx    = BB_WAIT;
          end else begin
            w_ready_nx = 1'b1;
            w_err_nx   = 1'b1;
            w_rdata_nx = '0;
            w_state_nx = BB_DONE;
          end
        end
      end
      BB_WAIT: begin
        // Ack is checked first so it beats a coincident timeout.
        if (w_ack) begin
          w_ch_req_nx = '0;
          w_rdata_nx  = r_ch_we ? '0 : w_sel_rdata;
          w_ready_nx  = 1'b1;
          w_state_nx  = BB_DONE;
        end else if (r_cnt == LP_LAST) begin
          w_ch_req_nx = '0;
          w_rdata_nx  = '0;
          w_ready_nx  = 1'b1;
          w_err_nx    = 1'b1;
          w_state_nx  = BB_DONE;
        end else begin
          w_cnt_nx = r_cnt + BB_CNT_W'(1);
        end
      end
      BB_DONE: w_state_nx = BB_IDLE;
      default: w_state_nx = BB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BB_IDLE;
      r_cnt      <= '0;
      r_ch_req   <= '0;
      r_ch_we    <= 1'b0;
      r_ch_addr  <= '0;
      r_ch_wdata <= '0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_ch_req   <= w_ch_req_nx;
      r_ch_we    <= w_ch_we_nx;
      r_ch_addr  <= w_ch_addr_nx;
      r_ch_wdata <= w_ch_wdata_nx;
      r_rdata    <= w_rdata_nx;
      r_ready    <= w_ready_nx;
      r_err      <= w_err_nx;
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_ready = r_ready;
  assign cpu_err   = r_err;
  assign ch_req    = r_ch_req;
  assign ch_we     = r_ch_we;
  assign ch_addr   = r_ch_addr;
  assign ch_wdata  = r_ch_wdata;

endmodule
